// File: rtl/op_sequencer.sv
// op_sequencer: FETCH/DECODE/EXEC/WB/DONE sequencer driving a 2-bit control decoder.
// Define SEQ_STEP_EN to add the step port, which holds FETCH until step is seen high.
module op_sequencer #(
    parameter int PC_W    = 4,
    parameter int LAST_PC = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef SEQ_STEP_EN
    input  logic            step,
`endif
    input  logic [2:0]      instr,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      op,
    output logic            ctrl_valid,
    output logic            wb_en,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE} state_t;
    state_t     state, state_n;
    logic [2:0] ir;
    logic       cnt;
    logic       adv;
    logic       last;
`ifdef SEQ_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif
    assign last = pc == PC_W'(LAST_PC);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // ir[1] marks the two-cycle opcodes; cnt is 0 on the first EXEC cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = adv ? DECODE : FETCH;
            DECODE:  state_n = ir[2] ? DONE : EXEC;
            EXEC:    state_n = (ir[1] && !cnt) ? EXEC : WB;
            WB:      state_n = last ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            op         <= '0;
            ir         <= '0;
            cnt        <= 1'b0;
            ctrl_valid <= 1'b0;
            wb_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ctrl_valid <= state_n == EXEC;
            wb_en      <= state_n == WB;
            busy       <= state_n != IDLE;
            done       <= state_n == DONE;
            cnt        <= state == EXEC;
            ir         <= (state == FETCH && adv) ? instr : ir;
            op         <= (state == DECODE && !ir[2]) ? ir[1:0] : op;
            pc         <= (state == IDLE && start) ? '0 :
                          (state == WB) ? (last ? '0 : pc + PC_W'(1)) : pc;
        end
    end
endmodule
